booth_mac_accumulator: RTL

//  Downstream consumer of the 7x7 signed Booth multiplier (done / 14-bit product).
//  - Accumulates a programmed number of signed products into one dot-product sum; this is the MAC half of a systolic PE.
//  - Captures one product per rising edge of mul_done and presents the sum with a valid/ready handshake.

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_done_edge.sv | 27 ++
 rtl/booth_mac_accumulator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier, MAC accumulator and PE array.
package booth_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned PROD_W = 2 * OP_W;
  // Widest accumulator (32) plus its overflow guard bit.
  localparam int unsigned EXT_W  = 33;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} mac_state_t;

  // Sign-extend a product; callers keep the low ACC_W(+1) bits they need.
  function automatic logic [EXT_W-1:0] sext_prod(input logic [PROD_W-1:0] prod);
    return {{(EXT_W - PROD_W){prod[PROD_W-1]}}, prod};
  endfunction

endpackage

// File: rtl/booth_done_edge.sv
// Rising-edge detector for the multiplier done level (synchronous reset).
module booth_done_edge (
  input  logic clk,
  input  logic rst,
  input  logic done_i,
  output logic rise_o
);

  logic done_q, done_d;

  // Previous level of done, tracked in every state.
  always_comb begin
    done_d = done_i;
  end

  // Delay register for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign rise_o = done_i & ~done_q;

endmodule

// File: rtl/booth_mac_accumulator.sv
// Dot-product accumulator fed by the Booth multiplier; sum returned via valid/ready.
// Optional macro BOOTH_MAC_SAT_EN: saturate on overflow and raise sticky acc_ovf,
// otherwise the sum wraps and acc_ovf is tied low.
module booth_mac_accumulator #(
  parameter int unsigned PROD_W = 14,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dot_start,
  input  logic [LEN_W-1:0]  dot_len,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_result,
  output logic [ACC_W-1:0]  acc_result,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic [LEN_W-1:0]  prod_count,
  output logic              acc_ovf
);
  import booth_pkg::*;

  mac_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  logic             done_rise;

  logic [EXT_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] acc_next;
  logic             unused_prod_ext;

  booth_done_edge u_done_edge (
    .clk    (clk),
    .rst    (rst),
    .done_i (mul_done),
    .rise_o (done_rise)
  );

  // One guard bit above ACC_W: it disagrees with the MSB exactly on overflow.
  assign prod_ext        = sext_prod(mul_result);
  assign sum             = {acc_q[ACC_W-1], acc_q} + prod_ext[ACC_W:0];
  assign sum_ovf         = sum[ACC_W] ^ sum[ACC_W-1];
  assign cnt_inc         = cnt_q + 1'b1;
  assign unused_prod_ext = ^prod_ext;

`ifdef BOOTH_MAC_SAT_EN
  logic ovf_q, ovf_d;

  // Clamp toward the true sign (the guard bit) when the sum leaves range.
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (sum_ovf) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Sticky overflow: cleared by a new dot product, set by any saturating add.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && dot_start) begin
      ovf_d = 1'b0;
    end else if (state_q == ACCUM && done_rise && sum_ovf) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign acc_ovf = ovf_q;
`else
  logic unused_sum_ovf;

  assign acc_next       = sum[ACC_W-1:0];
  assign acc_ovf        = 1'b0;
  assign unused_sum_ovf = sum_ovf;
`endif

  // Next-state logic for FSM, product counter and accumulator.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        // A product rising together with dot_start is dropped: start wins.
        if (dot_start) begin
          len_d = dot_len;
          cnt_d = '0;
          acc_d = '0;
          if (dot_len == '0) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (done_rise) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (valid_q && acc_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

  assign acc_result = acc_q;
  assign acc_valid  = valid_q;
  assign busy       = (state_q != IDLE);
  assign prod_count = cnt_q;

endmodule
